hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It drives the write enables, flushes and bubbles of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects read-after-write hazards against in-flight writers and stalls fetch/decode until they clear, since the core has no forwarding. It also squashes wrong-path instructions when the EX stage redirects the PC.

## Interface
Parameters:
- `WB_WRITE_THROUGH`, default 1. When 1, the register file writes in the first half-cycle, so the MEM/WB writer is not checked for hazards.
- `CNT_W`, default 16. Width of the stall counter.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high.
- `id_rs`, input, 5: rs field of the instruction in ID.
- `id_rt`, input, 5: rt field of the instruction in ID.
- `id_uses_rs`, input, 1: the instruction in ID reads rs.
- `id_uses_rt`, input, 1: the instruction in ID reads rt.
- `id_dest`, input, 5: destination register of the instruction in ID.
- `id_reg_we`, input, 1: the instruction in ID writes the register file.
- `ex_redirect`, input, 1: a taken branch or jump in EX; the PC mux selects the target this cycle.
- `ext_hold`, input, 1: global freeze, e.g. memory busy.
- `pc_we`, output, 1: PC write enable.
- `ifid_we`, output, 1: IF/ID write enable.
- `ifid_flush`, output, 1: IF/ID loads a NOP (all zero) instead of the fetched word.
- `idex_we`, output, 1: ID/EX write enable.
- `idex_bubble`, output, 1: ID/EX loads zero controls (`reg_we`, `dm_we`, `pcmux` = 0).
- `exmem_we`, output, 1: EX/MEM write enable.
- `memwb_we`, output, 1: MEM/WB write enable.
- `stalled`, output, 1: the controller is in STALL this cycle.
- `stall_cycles`, output, CNT_W: saturating count of hazard-stall cycles.

## Operation
State:
- FSM with states RUN, STALL and FLUSH.
- `ifid_valid` flag.
- Scoreboard `sb[0..2]`, each entry `{valid, dest[4:0]}`. The entries track the ID/EX, EX/MEM and MEM/WB occupants.

Hazard definition:
- `hazard` = `ifid_valid` && ((`id_uses_rs` && `id_rs` != 0 && rs matches a checked valid `sb` dest) || the same test for rt).
- The checked entries are `sb[0..1]` when `WB_WRITE_THROUGH` = 1, otherwise `sb[0..2]`.
- Register $0 never creates a hazard.

Outputs are combinational from state, scoreboard and current inputs. Priority, highest first:
- `ext_hold`: all `*_we` = 0, `ifid_flush` = 0, `idex_bubble` = 0. Scoreboard, state, `ifid_valid` and counter hold. A redirect under hold is ignored; EX re-presents it because ID/EX is frozen.
- `ex_redirect`: all `*_we` = 1, `ifid_flush` = 1, `idex_bubble` = 1. Next state is FLUSH. `ifid_valid` <= 0. `sb[0]` <= invalid.
- `hazard`: `pc_we` = `ifid_we` = 0, `idex_we` = 1, `idex_bubble` = 1, `exmem_we` = `memwb_we` = 1. State is STALL. `sb[0]` <= invalid. `stall_cycles` increments, saturating at all ones.
- Otherwise: all `*_we` = 1, no flush, no bubble. State is RUN. `ifid_valid` <= 1. `sb[0]` <= {`id_reg_we` && `ifid_valid`, `id_dest`}.

Scoreboard and state transitions:
- Unless held, every edge shifts the scoreboard: `sb[2]` <= `sb[1]`, `sb[1]` <= `sb[0]`.
- FLUSH always exits to RUN or STALL on the next non-held edge, per the rules above.
- In FLUSH, `ifid_valid` = 0, so no hazard can be raised.
- `stalled` = 1 exactly when the current cycle takes the hazard branch.

## Timing
Reset (asynchronous):
- State = RUN, `ifid_valid` = 0, `sb` all invalid, `stall_cycles` = 0.
- While `reset` is high: all `*_we` = 0, `ifid_flush` = 0, `idex_bubble` = 0, `stalled` = 0.
- First cycle after release: all `*_we` = 1, no hazard possible.

Stall and redirect:
- Load-use (dependent instruction immediately behind the writer): 2 stall cycles with `WB_WRITE_THROUGH` = 1, 3 with 0.
- Redirect costs exactly 2 squashed slots: the IF/ID occupant becomes a NOP and the ID-stage instruction becomes a bubble.
- Redirect coinciding with a hazard: the redirect wins, and the stall counter does not increment.

Reset mid-operation clears everything immediately, with no pending redirect or stall retained.

## Structure
- The shared `cpu_defs` package holds the FSM state encoding (`ST_RUN` = 0, `ST_STALL` = 1, `ST_FLUSH` = 2), the `REG_ZERO` constant and the scoreboard entry width.
- One natural sub-module is `hazard_scoreboard`, which holds the 3-entry shift register plus the match logic and outputs `rs_hit` / `rt_hit`.
- The FSM, output decode and counter stay in `hazard_ctrl`.

## Test plan
- Reset, then 5 independent ALU ops (rs = 1, rt = 2, dest 8..12) → no stall; all `*_we` = 1 every cycle; `stall_cycles` = 0.
- Writer dest 8, then a reader with rs = 8 immediately behind → `stalled` for 2 cycles (3 with `WB_WRITE_THROUGH` = 0); `pc_we` = 0 and `idex_bubble` = 1 in those cycles; `stall_cycles` = 2.
- Writer dest 0, then a reader with rs = 0 → no stall.
- `ex_redirect` pulse → `ifid_flush` = `idex_bubble` = 1 that cycle; next cycle state FLUSH and no hazard even though `id_rs` matches `sb`; bubbles never set `sb` valid.
- Redirect and hazard in the same cycle → redirect behaviour; `stall_cycles` unchanged. `ext_hold` during STALL → all `*_we` = 0, and the stall resumes with the same remaining length after hold drops.
- Assert `reset` mid-stall → outputs immediately at reset values; `stall_cycles` = 0. Run 2^`CNT_W` + 3 stall cycles → `stall_cycles` saturates at 0xFFFF.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared definitions for the five-stage MIPS core pipeline control.
// Holds the hazard FSM state encoding, the register-zero constant and the
// scoreboard entry layout used by hazard_ctrl and hazard_scoreboard.
package cpu_defs;

  // Hazard controller FSM encoding.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_t;

  // $0 is hard-wired to zero, so it can never carry a true dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Number of in-flight writers tracked: ID/EX, EX/MEM, MEM/WB.
  localparam int SB_DEPTH = 3;

  // One scoreboard entry: a pending register write.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
  } sb_entry_t;

  localparam int SB_W = $bits(sb_entry_t);

  // True when entry e holds a pending write to register r.
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r);
    return e.valid && (e.dest == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: 3-entry shift register mirroring the destination
// registers of the ID/EX, EX/MEM and MEM/WB occupants, plus RAW match logic.
// Ports: clk/reset; advance shifts in new_entry; rs/rt/uses_* are the ID
// source operands; rs_hit/rt_hit flag a pending write to a checked entry.
module hazard_scoreboard
  import cpu_defs::*;
#(
  parameter int WB_WRITE_THROUGH = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      advance,
  input  sb_entry_t new_entry,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic      uses_rs,
  input  logic      uses_rt,
  output logic      rs_hit,
  output logic      rt_hit
);

  // With a write-through register file the MEM/WB writer lands in the first
  // half of the cycle, so only the two younger entries can still conflict.
  localparam int CHK_DEPTH = (WB_WRITE_THROUGH != 0) ? 2 : SB_DEPTH;

  // sb[0] = ID/EX occupant, sb[1] = EX/MEM, sb[2] = MEM/WB.
  sb_entry_t [SB_DEPTH-1:0] sb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb <= '0;
    end else if (advance) begin
      sb[2] <= sb[1];
      sb[1] <= sb[0];
      sb[0] <= new_entry;
    end
  end

  logic rs_chk;
  logic rt_chk;

  assign rs_chk = uses_rs && (rs != REG_ZERO);
  assign rt_chk = uses_rt && (rt != REG_ZERO);

  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < CHK_DEPTH; i++) begin
      if (rs_chk && sb_match(sb[i], rs)) rs_hit = 1'b1;
      if (rt_chk && sb_match(sb[i], rt)) rt_hit = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage MIPS core.
// Drives PC / IF/ID / ID/EX / EX/MEM / MEM/WB write enables, the IF/ID flush
// and ID/EX bubble; stalls fetch/decode on RAW hazards (no forwarding) and
// squashes wrong-path work on an EX redirect. ext_hold freezes everything.
// Outputs: *_we, ifid_flush, idex_bubble, stalled, stall_cycles (saturating).
module hazard_ctrl #(
  parameter int WB_WRITE_THROUGH = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_reg_we,
  input  logic             ex_redirect,
  input  logic             ext_hold,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             stalled,
  output logic [CNT_W-1:0] stall_cycles
);

  import cpu_defs::*;

  hz_state_t state;
  hz_state_t state_next;
  logic      ifid_valid;
  logic      ifid_valid_next;

  logic      rs_hit;
  logic      rt_hit;
  logic      hazard;

  // Mutually exclusive branch selects, in priority order.
  logic      take_redirect;
  logic      take_stall;
  logic      take_run;

  sb_entry_t sb_new;
  logic      sb_advance;

  // ---------------------------------------------------------------------
  // Scoreboard of in-flight writers
  // ---------------------------------------------------------------------
  hazard_scoreboard #(
    .WB_WRITE_THROUGH(WB_WRITE_THROUGH)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .advance  (sb_advance),
    .new_entry(sb_new),
    .rs       (id_rs),
    .rt       (id_rt),
    .uses_rs  (id_uses_rs),
    .uses_rt  (id_uses_rt),
    .rs_hit   (rs_hit),
    .rt_hit   (rt_hit)
  );

  // A stale or flushed IF/ID word must not raise a stall.
  assign hazard = ifid_valid && (rs_hit || rt_hit);

  always_comb begin
    take_redirect = 1'b0;
    take_stall    = 1'b0;
    take_run      = 1'b0;
    if (!ext_hold) begin
      if (ex_redirect) begin
        take_redirect = 1'b1;
      end else if (hazard) begin
        take_stall = 1'b1;
      end else begin
        take_run = 1'b1;
      end
    end
  end

  // Whatever enters ID/EX this edge: a bubble on redirect/stall, otherwise
  // the decoded instruction (which only counts if IF/ID held a real word).
  always_comb begin
    sb_advance   = !ext_hold;
    sb_new       = '0;
    if (take_run) begin
      sb_new.valid = id_reg_we && ifid_valid;
      sb_new.dest  = id_dest;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_next;
      ifid_valid <= ifid_valid_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    ifid_valid_next = ifid_valid;
    if (take_redirect) begin
      state_next      = ST_FLUSH;
      ifid_valid_next = 1'b0;
    end else if (take_stall) begin
      // IF/ID is frozen, so its occupant stays valid.
      state_next      = ST_STALL;
    end else if (take_run) begin
      state_next      = ST_RUN;
      ifid_valid_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: output decode (combinational from state, scoreboard, inputs)
  // ---------------------------------------------------------------------
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    stalled     = 1'b0;
    // Reset forces the quiescent outputs even though the selects are derived
    // from registers that are already being cleared asynchronously.
    if (!reset) begin
      if (take_redirect) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b1;
        idex_we     = 1'b1;
        idex_bubble = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
      end else if (take_stall) begin
        idex_we     = 1'b1;
        idex_bubble = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        stalled     = 1'b1;
      end else if (take_run) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Saturating hazard-stall counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (take_stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rs = 1'b0;
  logic       id_uses_rt = 1'b0;
  logic [4:0] id_dest = '0;
  logic       id_reg_we = 1'b0;
  logic       ex_redirect = 1'b0;
  logic       ext_hold = 1'b0;

  // Default instance: write-through register file, 16-bit counter.
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we, stalled;
  logic [15:0] stall_cycles;
  // Second instance: no write-through, 4-bit counter (saturation reachable).
  logic        n_pc_we, n_ifid_we, n_ifid_flush, n_idex_we, n_idex_bubble, n_exmem_we, n_memwb_we, n_stalled;
  logic [3:0]  n_stall_cycles;

  logic [6:0] ctl, n_ctl;
  assign ctl   = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we};
  assign n_ctl = {n_pc_we, n_ifid_we, n_ifid_flush, n_idex_we, n_idex_bubble, n_exmem_we, n_memwb_we};

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we}
  localparam logic [6:0] C_RUN   = 7'b1101011;
  localparam logic [6:0] C_STALL = 7'b0001111;
  localparam logic [6:0] C_REDIR = 7'b1111111;
  localparam logic [6:0] C_OFF   = 7'b0000000;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.WB_WRITE_THROUGH(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_we(id_reg_we), .ex_redirect(ex_redirect), .ext_hold(ext_hold),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .stalled(stalled), .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.WB_WRITE_THROUGH(0), .CNT_W(4)) dut_n (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_we(id_reg_we), .ex_redirect(ex_redirect), .ext_hold(ext_hold),
    .pc_we(n_pc_we), .ifid_we(n_ifid_we), .ifid_flush(n_ifid_flush), .idex_we(n_idex_we),
    .idex_bubble(n_idex_bubble), .exmem_we(n_exmem_we), .memwb_we(n_memwb_we),
    .stalled(n_stalled), .stall_cycles(n_stall_cycles)
  );

  always #5 clk = ~clk;

  // Watchdog: the bench uses fixed cycle counts, this only guards a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "timeout");
  end

  task automatic nop_in();
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_dest = '0; id_reg_we = 1'b0; ex_redirect = 1'b0; ext_hold = 1'b0;
  endtask

  task automatic id_set(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic [4:0] dest, input logic we);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt; id_dest = dest; id_reg_we = we;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Leaves the bench at posedge+1 of the first cycle after reset release.
  task automatic do_reset();
    nop_in();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    nop_in();
    ex_redirect = 1'b1;
    reset = 1'b1;
    #1;
    n_tests++; if (ctl !== C_OFF) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_OFF); end
    n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL reset_stalled: got %b expected 0", stalled); end
    n_tests++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", stall_cycles); end
    n_tests++; if (n_ctl !== C_OFF) begin n_fail++; $display("FAIL reset_ctl_n: got %b expected %b", n_ctl, C_OFF); end
    nxt(); nxt();
    reset = 1'b0;
    ex_redirect = 1'b0;
    // First cycle: IF/ID not yet valid, so this writer is not recorded.
    id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1);
    mid();
    n_tests++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL first_cycle_ctl: got %b expected %b", ctl, C_RUN); end
    nxt();
    id_set(5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b0);
    mid();
    n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL first_cycle_nohaz: got %b expected 0", stalled); end
    n_tests++; if (n_stalled !== 1'b0) begin n_fail++; $display("FAIL first_cycle_nohaz_n: got %b expected 0", n_stalled); end
    nxt();
  endtask

  task automatic test_independent();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      id_set(5'd1, 5'd2, 1'b1, 1'b1, 5'(8 + i), 1'b1);
      mid();
      n_tests++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL indep_ctl[%0d]: got %b expected %b", i, ctl, C_RUN); end
      n_tests++; if (n_stalled !== 1'b0) begin n_fail++; $display("FAIL indep_stall_n[%0d]: got %b expected 0", i, n_stalled); end
      nxt();
    end
    n_tests++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL indep_cnt: got %0d expected 0", stall_cycles); end
  endtask

  task automatic test_load_use();
    logic [3:0] exp_s, exp_n;
    exp_s = 4'b1100;  // per cycle c2..c5, MSB first
    exp_n = 4'b1110;
    do_reset();
    mid(); nxt();                                       // c0: invalid slot
    id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1);         // c1: writer $8
    mid(); nxt();
    id_set(5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0);         // c2..c5: reader of $8
    for (int c = 0; c < 4; c++) begin
      mid();
      n_tests++; if (stalled !== exp_s[3-c]) begin n_fail++; $display("FAIL loaduse_stalled[%0d]: got %b expected %b", c, stalled, exp_s[3-c]); end
      n_tests++; if (n_stalled !== exp_n[3-c]) begin n_fail++; $display("FAIL loaduse_stalled_n[%0d]: got %b expected %b", c, n_stalled, exp_n[3-c]); end
      n_tests++; if (ctl !== (exp_s[3-c] ? C_STALL : C_RUN)) begin n_fail++; $display("FAIL loaduse_ctl[%0d]: got %b expected %b", c, ctl, exp_s[3-c] ? C_STALL : C_RUN); end
      nxt();
    end
    n_tests++; if (stall_cycles !== 16'd2) begin n_fail++; $display("FAIL loaduse_cnt: got %0d expected 2", stall_cycles); end
    n_tests++; if (n_stall_cycles !== 4'd3) begin n_fail++; $display("FAIL loaduse_cnt_n: got %0d expected 3", n_stall_cycles); end
    // rt path: writer $5 then reader using rt only.
    id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    mid(); nxt();
    id_set(5'd5, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0);
    mid();
    n_tests++; if (ctl !== C_STALL) begin n_fail++; $display("FAIL rt_hazard_ctl: got %b expected %b", ctl, C_STALL); end
    nxt(); nxt();
    mid();
    n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL rt_hazard_clear: got %b expected 0", stalled); end
    nxt();
    n_tests++; if (stall_cycles !== 16'd4) begin n_fail++; $display("FAIL rt_hazard_cnt: got %0d expected 4", stall_cycles); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    mid(); nxt();
    id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);         // writer $0
    mid(); nxt();
    id_set(5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0);         // reader $0
    mid();
    n_tests++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL zero_ctl: got %b expected %b", ctl, C_RUN); end
    n_tests++; if (n_stalled !== 1'b0) begin n_fail++; $display("FAIL zero_stall_n: got %b expected 0", n_stalled); end
    nxt();
    id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1);         // writer $6
    mid(); nxt();
    id_set(5'd6, 5'd6, 1'b0, 1'b0, 5'd7, 1'b0);         // fields match, but unused
    mid();
    n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL unused_src_stall: got %b expected 0", stalled); end
    nxt();
    n_tests++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL zero_cnt: got %0d expected 0", stall_cycles); end
  endtask

  task automatic test_redirect();
    do_reset();
    mid(); nxt();
    id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1);         // writer $8
    mid(); nxt();
    id_set(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1);         // wrong-path writer $9
    ex_redirect = 1'b1;
    mid();
    n_tests++; if (ctl !== C_REDIR) begin n_fail++; $display("FAIL redir_ctl: got %b expected %b", ctl, C_REDIR); end
    n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL redir_stalled: got %b expected 0", stalled); end
    nxt();
    ex_redirect = 1'b0;
    id_set(5'd8, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1);        // FLUSH: $8 still in flight
    mid();
    n_tests++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL flush_nohaz_ctl: got %b expected %b", ctl, C_RUN); end
    n_tests++; if (n_stalled !== 1'b0) begin n_fail++; $display("FAIL flush_nohaz_n: got %b expected 0", n_stalled); end
    nxt();
    id_set(5'd10, 5'd9, 1'b1, 1'b1, 5'd11, 1'b0);       // bubbles never marked valid
    mid();
    n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL bubble_sb: got %b expected 0", stalled); end
    n_tests++; if (n_stalled !== 1'b0) begin n_fail++; $display("FAIL bubble_sb_n: got %b expected 0", n_stalled); end
    nxt();
  endtask

  task automatic test_redirect_hazard();
    do_reset();
    mid(); nxt();
    id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1);
    mid(); nxt();
    id_set(5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0);         // dependent reader
    ex_redirect = 1'b1;
    mid();
    n_tests++; if (ctl !== C_REDIR) begin n_fail++; $display("FAIL redir_haz_ctl: got %b expected %b", ctl, C_REDIR); end
    n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL redir_haz_stalled: got %b expected 0", stalled); end
    nxt();
    ex_redirect = 1'b0;
    n_tests++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL redir_haz_cnt: got %0d expected 0", stall_cycles); end
    mid();
    n_tests++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL redir_haz_after: got %b expected %b", ctl, C_RUN); end
    nxt();
  endtask

  task automatic test_hold();
    do_reset();
    mid(); nxt();
    id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1);
    mid(); nxt();
    id_set(5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0);
    mid();
    n_tests++; if (ctl !== C_STALL) begin n_fail++; $display("FAIL hold_pre_ctl: got %b expected %b", ctl, C_STALL); end
    nxt();
    ext_hold = 1'b1;
    ex_redirect = 1'b1;                                 // ignored under hold
    mid();
    n_tests++; if (ctl !== C_OFF) begin n_fail++; $display("FAIL hold_ctl: got %b expected %b", ctl, C_OFF); end
    n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL hold_stalled: got %b expected 0", stalled); end
    nxt();
    ex_redirect = 1'b0;
    mid();
    n_tests++; if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL hold_cnt: got %0d expected 1", stall_cycles); end
    nxt();
    ext_hold = 1'b0;
    mid();
    n_tests++; if (ctl !== C_STALL) begin n_fail++; $display("FAIL hold_resume: got %b expected %b", ctl, C_STALL); end
    nxt();
    mid();
    n_tests++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL hold_end: got %b expected %b", ctl, C_RUN); end
    nxt();
    n_tests++; if (stall_cycles !== 16'd2) begin n_fail++; $display("FAIL hold_cnt_end: got %0d expected 2", stall_cycles); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mid(); nxt();
    id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1);
    mid(); nxt();
    id_set(5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0);
    mid(); nxt();                                       // first stall taken
    reset = 1'b1;
    #1;
    n_tests++; if (ctl !== C_OFF) begin n_fail++; $display("FAIL rstmid_ctl: got %b expected %b", ctl, C_OFF); end
    n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL rstmid_stalled: got %b expected 0", stalled); end
    n_tests++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", stall_cycles); end
    nxt();
    reset = 1'b0;
    mid();
    n_tests++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL rstmid_rel0: got %b expected %b", ctl, C_RUN); end
    nxt();
    mid();
    n_tests++; if (ctl !== C_RUN) begin n_fail++; $display("FAIL rstmid_rel1: got %b expected %b", ctl, C_RUN); end
    nxt();
  endtask

  // Chain of dependent writers on the non-write-through instance: each link
  // costs 3 stall cycles, so its 4-bit counter saturates after 5 links.
  task automatic test_saturation();
    int exp_cnt;
    logic [4:0] prev, cur;
    do_reset();
    mid(); nxt();
    prev = 5'd8;
    id_set(5'd0, 5'd0, 1'b0, 1'b0, prev, 1'b1);
    mid(); nxt();
    for (int k = 1; k <= 7; k++) begin
      cur = (prev == 5'd8) ? 5'd9 : 5'd8;
      id_set(prev, 5'd0, 1'b1, 1'b0, cur, 1'b1);
      for (int c = 0; c < 4; c++) begin
        mid();
        n_tests++; if (n_stalled !== (c < 3)) begin n_fail++; $display("FAIL sat_stalled_n[%0d.%0d]: got %b expected %b", k, c, n_stalled, (c < 3)); end
        nxt();
      end
      exp_cnt = (3 * k > 15) ? 15 : 3 * k;
      n_tests++; if (n_stall_cycles !== 4'(exp_cnt)) begin n_fail++; $display("FAIL sat_cnt_n[%0d]: got %0d expected %0d", k, n_stall_cycles, exp_cnt); end
      prev = cur;
    end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_load_use();
    test_reg_zero();
    test_redirect();
    test_redirect_hazard();
    test_hold();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
